// File: rtl/sample_word_port_pkg.sv
// Shared constants, state encoding and lane helpers for the sample word port.
package sample_word_port_pkg;

    localparam int SAMPLE_W = 12;
    localparam int LANES    = 3;
    localparam int WORD_W   = SAMPLE_W * LANES;
    localparam int ADDR_W   = 19;
    localparam int RD_LAT   = 2;   // the read pipeline below assumes RD_LAT >= 2

    // Address map shared with the address calculator.
    localparam logic [ADDR_W-1:0] SONG0_START = 19'd0;
    localparam logic [ADDR_W-1:0] SONG1_START = 19'd120000;
    localparam logic [ADDR_W-1:0] SONG2_START = 19'd240000;
    localparam logic [ADDR_W-1:0] MAX_ADDR    = 19'd359999;

    // Lane 0 is the most significant sample of a memory word.
    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 12;
    localparam int LANE2_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2,
        ST_REC   = 2'd3
    } state_t;

    typedef logic [1:0] slot_t;
    localparam slot_t LAST_SLOT = 2'd2;

    function automatic logic [SAMPLE_W-1:0] lane_get(input logic [WORD_W-1:0] word, input slot_t slot);
        logic [SAMPLE_W-1:0] v;
        case (slot)
            2'd0:    v = word[LANE0_LSB +: SAMPLE_W];
            2'd1:    v = word[LANE1_LSB +: SAMPLE_W];
            2'd2:    v = word[LANE2_LSB +: SAMPLE_W];
            default: v = {SAMPLE_W{1'b0}};
        endcase
        return v;
    endfunction

    function automatic logic [WORD_W-1:0] lane_set(input logic [WORD_W-1:0] word, input slot_t slot,
                                                   input logic [SAMPLE_W-1:0] smp);
        logic [WORD_W-1:0] v;
        v = word;
        case (slot)
            2'd0:    v[LANE0_LSB +: SAMPLE_W] = smp;
            2'd1:    v[LANE1_LSB +: SAMPLE_W] = smp;
            2'd2:    v[LANE2_LSB +: SAMPLE_W] = smp;
            default: v = word;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sample_word_port_if.sv
// Memory-side bus between the sample word port (master) and the ZBT wrapper (slave).
interface sample_word_port_if;
    import sample_word_port_pkg::*;

    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_rd;
    logic [WORD_W-1:0] mem_rdata;

    modport master (output mem_addr_out, output mem_we, output mem_wdata, output mem_rd, input mem_rdata);
    modport slave  (input mem_addr_out, input mem_we, input mem_wdata, input mem_rd, output mem_rdata);
endinterface

// File: rtl/sample_word_port_packer.sv
// Three-lane word register: packs samples by slot when recording,
// holds the word being unpacked when playing.
module sample_packer
    import sample_word_port_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_load,
    input  logic [WORD_W-1:0]   i_word,
    input  logic                i_wr_lane,
    input  slot_t               i_slot,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic [WORD_W-1:0]   o_word,
    output logic [SAMPLE_W-1:0] o_lane
);

    logic [WORD_W-1:0] r_word;

    // Word register: clear beats load beats lane write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= {WORD_W{1'b0}};
        end else if (i_clr) begin
            r_word <= {WORD_W{1'b0}};
        end else if (i_load) begin
            r_word <= i_word;
        end else if (i_wr_lane) begin
            r_word <= lane_set(r_word, i_slot, i_sample);
        end else begin
            r_word <= r_word;
        end
    end

    assign o_word = r_word;
    assign o_lane = lane_get(r_word, i_slot);

endmodule

// File: rtl/sample_word_port.sv
// Moves audio between the AC97 sample stream and 36-bit sample memory:
// packs three samples per word when recording, prefetches and unpacks when playing.
module sample_word_port
    import sample_word_port_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready,
    input  logic                 start_song,
    input  logic                 record_mode,
    input  logic                 pause_song,
    input  logic                 song_done,
    input  logic [ADDR_W-1:0]    mem_address,
    input  logic [SAMPLE_W-1:0]  sample_in,
    output logic [SAMPLE_W-1:0]  sample_out,
    output logic                 sample_valid,
    sample_word_port_if.master   mem
);

    state_t            r_state;
    state_t            w_state_nxt;
    slot_t             r_slot;
    logic              r_prime_issued;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WORD_W-1:0] r_nxt_word;
    logic [RD_LAT-1:0] r_rd_pipe;

    logic              w_land;
    logic              w_go;
    logic              w_prime_rd;
    logic              w_play_step;
    logic              w_rec_step;
    logic              w_play_rd;
    logic              w_rec_wr;
    logic              w_pk_load;
    logic [WORD_W-1:0] w_pk_word_in;
    logic [WORD_W-1:0] w_pk_word;
    logic [SAMPLE_W-1:0] w_pk_lane;

    // A read issued RD_LAT cycles ago has its data on mem_rdata now.
    assign w_land = r_rd_pipe[RD_LAT-1];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start wins over song end, song end over the prime landing.
    always_comb begin
        w_state_nxt = r_state;
        if (start_song) begin
            w_state_nxt = record_mode ? ST_REC : ST_PRIME;
        end else if (song_done && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end else if ((r_state == ST_PRIME) && w_land) begin
            w_state_nxt = ST_PLAY;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Per-cycle controls derived from state, slot and the sample-frame inputs.
    always_comb begin
        w_go        = ready & ~pause_song & ~song_done & ~start_song &
                      ((r_state == ST_REC) | (r_state == ST_PLAY));
        w_prime_rd  = (r_state == ST_PRIME) & ~r_prime_issued & ~pause_song & ~song_done & ~start_song;
        w_play_step = w_go & (r_state == ST_PLAY);
        w_rec_step  = w_go & (r_state == ST_REC);
        w_play_rd   = w_play_step & (r_slot == 2'd1);
        w_rec_wr    = w_rec_step & (r_slot == LAST_SLOT);
        w_pk_load   = (~start_song & w_land & (r_state == ST_PRIME)) |
                      (w_play_step & (r_slot == LAST_SLOT));
        if (r_state == ST_PRIME) begin
            w_pk_word_in = mem.mem_rdata;
        end else begin
            w_pk_word_in = r_nxt_word;
        end
    end

    sample_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (start_song),
        .i_load    (w_pk_load),
        .i_word    (w_pk_word_in),
        .i_wr_lane (w_rec_step),
        .i_slot    (r_slot),
        .i_sample  (sample_in),
        .o_word    (w_pk_word),
        .o_lane    (w_pk_lane)
    );

    // Slot counter, prime flag, write address, prefetch word and read pipeline.
    always_ff @(posedge clk) begin
        if (reset || start_song) begin
            r_slot         <= 2'd0;
            r_prime_issued <= 1'b0;
            r_wr_addr      <= {ADDR_W{1'b0}};
            r_nxt_word     <= {WORD_W{1'b0}};
            r_rd_pipe      <= {RD_LAT{1'b0}};
        end else begin
            r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], mem.mem_rd};
            if (song_done && (r_state != ST_IDLE)) begin
                r_slot <= 2'd0;
            end else if (w_go) begin
                r_slot <= (r_slot == LAST_SLOT) ? 2'd0 : r_slot + 2'd1;
            end else begin
                r_slot <= r_slot;
            end
            if (w_prime_rd) begin
                r_prime_issued <= 1'b1;
            end else begin
                r_prime_issued <= r_prime_issued;
            end
            if (w_rec_step && (r_slot == 2'd0)) begin
                r_wr_addr <= mem_address;
            end else begin
                r_wr_addr <= r_wr_addr;
            end
            if (w_land && (r_state != ST_PRIME)) begin
                r_nxt_word <= mem.mem_rdata;
            end else begin
                r_nxt_word <= r_nxt_word;
            end
        end
    end

    // Registered outputs: single-cycle strobes, held address/data/sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out       <= {SAMPLE_W{1'b0}};
            sample_valid     <= 1'b0;
            mem.mem_we       <= 1'b0;
            mem.mem_rd       <= 1'b0;
            mem.mem_addr_out <= {ADDR_W{1'b0}};
            mem.mem_wdata    <= {WORD_W{1'b0}};
        end else begin
            sample_valid <= w_play_step;
            mem.mem_we   <= w_rec_wr;
            mem.mem_rd   <= w_prime_rd | w_play_rd;
            if (w_play_step) begin
                sample_out <= w_pk_lane;
            end else begin
                sample_out <= sample_out;
            end
            if (w_rec_wr) begin
                mem.mem_addr_out <= r_wr_addr;
                mem.mem_wdata    <= lane_set(w_pk_word, LAST_SLOT, sample_in);
            end else if (w_prime_rd || w_play_rd) begin
                mem.mem_addr_out <= mem_address;
                mem.mem_wdata    <= mem.mem_wdata;
            end else begin
                mem.mem_addr_out <= mem.mem_addr_out;
                mem.mem_wdata    <= mem.mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sample_word_port.sv
// Self-checking bench for sample_word_port: table-driven record/playback
// vectors, hand sequences for pause, song end and reset, scoreboard on strobes.
module tb_sample_word_port;
    import sample_word_port_pkg::*;

    localparam int EV_SMP = 0;
    localparam int EV_WR  = 1;
    localparam int EV_RD  = 2;
    localparam int M_IDLE = 0;
    localparam int M_REC  = 1;
    localparam int M_PRIME = 2;
    localparam int M_PLAY = 3;

    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } ev_t;

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [SAMPLE_W-1:0] s0;
        logic [SAMPLE_W-1:0] s1;
        logic [SAMPLE_W-1:0] s2;
        logic [WORD_W-1:0]   exp_wdata;
    } rec_vec_t;

    typedef struct {
        logic [ADDR_W-1:0]     addr;
        logic [WORD_W-1:0]     w0;
        logic [WORD_W-1:0]     w1;
        logic [6*SAMPLE_W-1:0] exp_smp;
    } play_vec_t;

    logic                clk = 1'b0;
    logic                reset, ready, start_song, record_mode, pause_song, song_done;
    logic [ADDR_W-1:0]   mem_address;
    logic [SAMPLE_W-1:0] sample_in;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;

    int n_checks = 0;
    int n_errs   = 0;
    ev_t exp_q[$];
    int  m_mode = M_IDLE;
    int  m_slot = 0;

    logic [WORD_W-1:0] mem_model [int];
    logic [WORD_W-1:0] d_pipe [RD_LAT];

    rec_vec_t  rec_tab  [3];
    play_vec_t play_tab [2];

    sample_word_port_if u_if ();

    sample_word_port dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .start_song   (start_song),
        .record_mode  (record_mode),
        .pause_song   (pause_song),
        .song_done    (song_done),
        .mem_address  (mem_address),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .mem          (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] model_rd(input int a);
        if (mem_model.exists(a)) return mem_model[a];
        return {WORD_W{1'b0}};
    endfunction

    // Memory model: read data appears RD_LAT cycles after the mem_rd cycle.
    always @(posedge clk) begin
        d_pipe[0] <= u_if.mem_rd ? model_rd(int'(u_if.mem_addr_out)) : {WORD_W{1'b0}};
        for (int i = 1; i < RD_LAT; i++) d_pipe[i] <= d_pipe[i-1];
    end
    assign u_if.mem_rdata = d_pipe[RD_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic exp_push(input int kind, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h, expected no event", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr !== a || e.data !== d) begin
                n_errs++;
                $display("FAIL event: got kind=%0d addr=%0d data=%h, expected kind=%0d addr=%0d data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every strobe seen on the falling edge must match the scoreboard head.
    always @(negedge clk) begin
        if (u_if.mem_we || u_if.mem_rd) begin
            n_checks++;
            if (u_if.mem_we && u_if.mem_rd) begin
                n_errs++;
                $display("FAIL we_rd_exclusive: got we=1 rd=1, expected at most one");
            end
        end
        if (sample_valid) pop_cmp(EV_SMP, {ADDR_W{1'b0}}, {{(WORD_W-SAMPLE_W){1'b0}}, sample_out});
        if (u_if.mem_we)  pop_cmp(EV_WR, u_if.mem_addr_out, u_if.mem_wdata);
        if (u_if.mem_rd)  pop_cmp(EV_RD, u_if.mem_addr_out, {WORD_W{1'b0}});
    end

    task automatic start_seq(input logic rec, input logic [ADDR_W-1:0] a);
        mem_address = a;
        record_mode = rec;
        start_song  = 1'b1;
        m_slot      = 0;
        m_mode      = rec ? M_REC : M_PRIME;
        if (!rec) exp_push(EV_RD, a, {WORD_W{1'b0}});
        tick();
        start_song = 1'b0;
        if (!rec) begin
            ready = 1'b1;          // falls inside PRIME: must be ignored
            tick();
            ready = 1'b0;
        end
        repeat (8) tick();
        if (!rec) m_mode = M_PLAY;
    endtask

    task automatic ready_pulse(input logic [SAMPLE_W-1:0] s, input logic [SAMPLE_W-1:0] exp_s);
        bit act;
        bit last;
        act  = ((m_mode == M_REC) || (m_mode == M_PLAY)) && !pause_song;
        last = (m_slot == 2);
        ready     = 1'b1;
        sample_in = s;
        if (act && m_mode == M_PLAY) begin
            exp_push(EV_SMP, {ADDR_W{1'b0}}, {{(WORD_W-SAMPLE_W){1'b0}}, exp_s});
            if (m_slot == 1) exp_push(EV_RD, mem_address, {WORD_W{1'b0}});
        end
        tick();
        ready = 1'b0;
        if (act && m_mode == M_PLAY) chk("valid_strobe", {63'd0, sample_valid}, 64'd1);
        if (act && m_mode == M_REC && last) chk("we_strobe", {63'd0, u_if.mem_we}, 64'd1);
        if (act) begin
            if (m_slot == 0) mem_address = mem_address + 19'd1;
            m_slot = last ? 0 : m_slot + 1;
        end
        repeat (5) tick();
    endtask

    task automatic drain(input string name);
        repeat (10) tick();
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_sample_out"}, 64'(sample_out), 64'd0);
        chk({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
        chk({tag, "_mem_we"}, 64'(u_if.mem_we), 64'd0);
        chk({tag, "_mem_rd"}, 64'(u_if.mem_rd), 64'd0);
        chk({tag, "_mem_addr"}, 64'(u_if.mem_addr_out), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(u_if.mem_wdata), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_tab[0] = '{19'd240000, 12'h111, 12'h222, 12'h333, 36'h111222333};
        rec_tab[1] = '{19'd100,    12'hFFF, 12'h000, 12'hA5A, 36'hFFF000A5A};
        rec_tab[2] = '{19'h7FFF0,  12'h001, 12'h800, 12'h7FF, 36'h0018007FF};
        play_tab[0] = '{19'd0,    36'hABC123456, 36'hFED987654, 72'hABC123456FED987654};
        play_tab[1] = '{19'd5000, 36'h000FFF800, 36'h7FF001A5A, 72'h000FFF8007FF001A5A};

        reset = 1'b1; ready = 1'b0; start_song = 1'b0; record_mode = 1'b0;
        pause_song = 1'b0; song_done = 1'b0; mem_address = 19'd0; sample_in = 12'd0;
        tick(); tick();
        chk_quiet("reset");
        reset = 1'b0;
        tick();

        // Record: three samples -> one packed write one cycle after the third ready.
        for (int i = 0; i < 3; i++) begin
            start_seq(1'b1, rec_tab[i].addr);
            exp_push(EV_WR, rec_tab[i].addr, rec_tab[i].exp_wdata);
            ready_pulse(rec_tab[i].s0, 12'd0);
            ready_pulse(rec_tab[i].s1, 12'd0);
            ready_pulse(rec_tab[i].s2, 12'd0);
            drain("rec_drain");
        end

        // Playback: prime, unpack, prefetch on slot 1, fourth ready shows word 1 lane 0.
        for (int i = 0; i < 2; i++) begin
            mem_model[int'(play_tab[i].addr)]      = play_tab[i].w0;
            mem_model[int'(play_tab[i].addr) + 1]  = play_tab[i].w1;
            start_seq(1'b0, play_tab[i].addr);
            for (int k = 0; k < 6; k++)
                ready_pulse(12'd0, play_tab[i].exp_smp[6*SAMPLE_W-1-SAMPLE_W*k -: SAMPLE_W]);
            drain("play_drain");
        end

        // Pause mid-triple: five ignored readies, then the slot resumes where it was.
        mem_model[7000] = 36'h123456789;
        mem_model[7001] = 36'hABCDEF012;
        start_seq(1'b0, 19'd7000);
        ready_pulse(12'd0, 12'h123);
        pause_song = 1'b1;
        repeat (5) ready_pulse(12'd0, 12'd0);
        chk("pause_quiet", 64'(exp_q.size()), 64'd0);
        pause_song = 1'b0;
        ready_pulse(12'd0, 12'h456);
        ready_pulse(12'd0, 12'h789);
        ready_pulse(12'd0, 12'hABC);
        ready_pulse(12'd0, 12'hDEF);
        ready_pulse(12'd0, 12'h012);
        drain("pause_drain");

        // Song end with a partial record word: nothing written, back to idle.
        start_seq(1'b1, 19'd300);
        ready_pulse(12'hAAA, 12'd0);
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        m_mode = M_IDLE; m_slot = 0;
        ready_pulse(12'hBBB, 12'd0);
        ready_pulse(12'hCCC, 12'd0);
        drain("no_partial_write");
        mem_model[400] = 36'h2468ACE13;
        start_seq(1'b0, 19'd400);
        ready_pulse(12'd0, 12'h246);
        ready_pulse(12'd0, 12'h8AC);
        ready_pulse(12'd0, 12'hE13);
        drain("after_done_play");

        // Reset mid-play: outputs clear, readies ignored until the next start.
        mem_model[9000] = 36'h13579BDF0;
        start_seq(1'b0, 19'd9000);
        ready_pulse(12'd0, 12'h135);
        reset = 1'b1;
        tick();
        chk_quiet("midreset");
        reset = 1'b0;
        m_mode = M_IDLE; m_slot = 0;
        ready_pulse(12'd0, 12'd0);
        ready_pulse(12'd0, 12'd0);
        drain("reset_ignore");
        start_seq(1'b0, 19'd9000);
        ready_pulse(12'd0, 12'h135);
        ready_pulse(12'd0, 12'h79B);
        ready_pulse(12'd0, 12'hDF0);
        drain("after_reset_play");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_word_port.md
Name: sample_word_port

Overview:
- Memory-side counterpart of the address calculator: consumes its mem_address/song_done and moves audio between the AC97 sample stream and the 36-bit sample memory.
- Record: packs three 12-bit samples per memory word and issues a write.
- Playback: prefetches words and unpacks them into one sample per ready pulse.
- Sits between the AC97 data path, the address calculator and the ZBT memory wrapper.

Parameters:
- SAMPLE_W, 12, bits per audio sample (lane width)
- LANES, 3, samples per memory word; ready triples match address increments
- WORD_W, 36, memory data width (= SAMPLE_W*LANES)
- ADDR_W, 19, memory address width
- RD_LAT, 2, cycles from mem_rd to valid mem_rdata

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ready  in  1  one-cycle pulse per AC97 sample frame
- start_song  in  1  FSM start pulse (same pulse the address calculator sees)
- record_mode  in  1  1=record, 0=playback; sampled on start_song
- pause_song  in  1  hold; ready is ignored while high
- song_done  in  1  from the address calculator; ends activity
- mem_address  in  ADDR_W  current address from the address calculator
- sample_in  in  SAMPLE_W  AC97 input sample, valid with ready
- sample_out  out  SAMPLE_W  playback sample
- sample_valid  out  1  one-cycle pulse when sample_out updates
- mem_addr_out  out  ADDR_W  address for mem_we/mem_rd
- mem_we  out  1  one-cycle write strobe
- mem_wdata  out  WORD_W  packed write word
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  WORD_W  read data, valid RD_LAT cycles after mem_rd

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset:
  - state=IDLE, slot=0.
  - sample_out=0, sample_valid=0, mem_we=0, mem_rd=0, mem_addr_out=0, mem_wdata=0.
  - cur_word=0, nxt_word=0, rd pipeline cleared.
- Lane order: lane 0 = bits [35:24], lane 1 = [23:12], lane 2 = [11:0].
- "Active ready" means ready & ~pause_song & ~song_done & (state is REC or PLAY).
- slot counts 0,1,2,0 on each active ready.
- States and transitions:
  - IDLE: outputs quiet. start_song & record_mode -> REC. start_song & ~record_mode -> PRIME.
  - PRIME:
    - Cycle after entry: mem_rd=1, mem_addr_out=mem_address, so the first word is fetched.
    - After RD_LAT cycles: cur_word<=mem_rdata, go to PLAY.
    - ready pulses during PRIME are ignored.
  - PLAY, on active ready:
    - sample_out<=lane[slot] of cur_word; sample_valid=1 the next cycle.
    - slot 1: mem_rd=1, mem_addr_out=mem_address (already advanced by the address calculator after slot 0); nxt_word captured RD_LAT later.
    - slot 2: after output, cur_word<=nxt_word.
    - If speed/slow changes the address, whatever word is at mem_address is read; no correction.
  - REC, on active ready:
    - Store sample_in into lane[slot] of the packing register.
    - slot 0: latch wr_addr<=mem_address (pre-increment value).
    - slot 2: next cycle mem_we=1, mem_addr_out=wr_addr, mem_wdata=packed word (all three lanes, including the current sample).
- song_done high in REC/PLAY/PRIME -> IDLE next cycle, slot<=0.
  - A partial REC word (slot≠0) is discarded, never written.
  - A write already scheduled for that cycle still completes.
- start_song in any state restarts: slot<=0, buffers cleared, enter REC or PRIME per record_mode. start_song wins over a simultaneous ready or song_done.
- pause_song: slot, buffers and state are held; no strobes are issued. An in-flight read still lands in nxt_word/cur_word.
- mem_we and mem_rd are never high in the same cycle. Each is high for exactly one cycle per event.
- reset mid-song: immediately returns to reset values; no strobe is emitted in the reset cycle.

Decomposition:
- Shared package: SAMPLE_W, LANES, WORD_W, ADDR_W, RD_LAT, the state encoding (IDLE/PRIME/PLAY/REC), and lane bit-slice constants. The address map constants (song start addresses, MAX_ADDR) also move there.
- One natural sub-module: sample_packer. It is a slot-indexed 3-lane pack/unpack register with load/shift controls, used for both the REC pack and the PLAY unpack.

Test Plan:
- Record: start_song, record_mode=1, mem_address=240000; ready×3 with samples 0x111, 0x222, 0x333 -> one mem_we, addr 240000, wdata 0x111222333, one cycle after the third ready.
- Playback prime: start_song, record_mode=0, mem_address=0, mem_rdata=0xABC123456 at RD_LAT -> mem_rd at cycle 1; on ready×3, sample_out = 0xABC, 0x123, 0x456, each with a sample_valid pulse.
- Prefetch: PLAY with mem_address advancing to 1 after the first ready -> mem_rd with addr 1 on the second ready; the fourth ready outputs lane 0 of word 1.
- Pause: pause_song high across 5 ready pulses mid-triple -> no sample_valid, mem_we or mem_rd; slot resumes at its held value afterward.
- Song end: REC at slot 1 when song_done rises -> no mem_we, state IDLE. A later start_song with record_mode=0 enters PRIME.
- Reset mid-PLAY: reset asserted one cycle -> all outputs 0 next cycle; ready is ignored until start_song.
